// File: rtl/fetch_queue.sv
// Purpose: instruction fetch unit with a small in-order queue of {pc, instr} entries.
// Latency: a response enters the queue on data_ok and is visible on out_* the next cycle.
// Backpressure: out_valid/out_ready handshake; no new fetch is issued while the queue is full.
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   ireq / iresp       instruction bus request (valid, addr) and response (data_ok, data[31:0])
//   redir_valid/_pc    one-cycle redirect strobe and target from branch resolution
//   out_valid/_ready   head-of-queue handshake; out_pc / out_instr carry the head entry
//   occupancy          current entry count
//   drop_cnt           saturating count of responses discarded because of a redirect

package fetch_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [1:0]  size;
        logic        wr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic        err;
        logic [63:0] data;
    } ibus_resp_t;

endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output ibus_req_t                  ireq,
    input  ibus_resp_t                 iresp,
    input  logic                       redir_valid,
    input  logic [63:0]                redir_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [31:0]                drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [63:0]   r_fpc;
    logic [63:0]   w_fpc_nxt;
    // Address of the request in flight; stays put in DROP even though fpc has moved on.
    logic [63:0]   r_req_addr;

    logic [63:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [31:0]   r_drop_cnt;

    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_issue;
    logic          w_has_room;
    logic          w_empty;

    // Only data_ok and the low instruction word of the response are consumed.
    logic          w_unused_resp;
    assign w_unused_resp = ^{iresp.err, iresp.data[63:32]};

    assign w_empty    = (r_count == '0);
    assign w_has_room = (r_count < CW'(DEPTH));
    // A redirect flushes the queue, so a pop in the same cycle is meaningless.
    assign w_pop      = !w_empty && out_ready && !redir_valid;

    // ------------------------------------------------------------------
    // Fetch FSM: next state, next fetch PC, push/drop/issue strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_fpc_nxt   = r_fpc;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        w_issue     = 1'b0;

        case (r_state)
            IDLE: begin
                if (redir_valid) begin
                    w_fpc_nxt = redir_pc;
                end else if (w_has_room) begin
                    w_issue     = 1'b1;
                    w_state_nxt = REQ;
                end
            end

            REQ: begin
                if (iresp.data_ok) begin
                    w_state_nxt = IDLE;
                    if (redir_valid) begin
                        // Response belongs to the old path: discard it.
                        w_drop    = 1'b1;
                        w_fpc_nxt = redir_pc;
                    end else begin
                        w_push    = 1'b1;
                        w_fpc_nxt = r_fpc + 64'd4;
                    end
                end else if (redir_valid) begin
                    // Bus request cannot be withdrawn; wait for it and throw it away.
                    w_state_nxt = DROP;
                    w_fpc_nxt   = redir_pc;
                end
            end

            DROP: begin
                if (iresp.data_ok) begin
                    w_drop      = 1'b1;
                    w_state_nxt = IDLE;
                end
                if (redir_valid) begin
                    w_fpc_nxt = redir_pc;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_fpc      <= RESET_PC;
            r_req_addr <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fpc   <= w_fpc_nxt;

            if (w_issue) begin
                r_req_addr <= r_fpc;
            end

            if (redir_valid) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + AW'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end

            if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
        end
    end

    // Entry storage needs no reset: it is only observed through out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]    <= r_req_addr;
            r_instr_mem[r_tail] <= iresp.data[31:0];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ireq       = '0;
        ireq.valid = (r_state != IDLE);
        ireq.addr  = (r_state != IDLE) ? r_req_addr : 64'd0;
    end

    assign out_valid = !w_empty;
    assign out_pc    = w_empty ? 64'd0 : r_pc_mem[r_head];
    assign out_instr = w_empty ? 32'd0 : r_instr_mem[r_head];
    assign occupancy = r_count;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Purpose: randomized bench for fetch_queue against a transaction-level queue model.
// Latency: outputs sampled on the falling edge, one model step per rising edge.
// Backpressure: out_ready and response latency are randomized per phase.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;
    logic [31:0] drop_cnt;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ireq        (ireq),
        .iresp       (iresp),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .occupancy   (occupancy),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of fetched entries plus one outstanding fetch
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        m_q[$];
    bit          m_busy;     // a fetch is on the bus
    bit          m_doomed;   // its response will be thrown away
    bit          m_fresh;    // nothing pushed since reset
    logic [63:0] m_addr;
    logic [63:0] m_fpc;
    logic [31:0] m_drop;

    function automatic void model_reset();
        m_q.delete();
        m_busy   = 1'b0;
        m_doomed = 1'b0;
        m_fresh  = 1'b1;
        m_addr   = 64'd0;
        m_fpc    = RESET_PC;
        m_drop   = 32'd0;
    endfunction

    function automatic void model_step();
        int   n_before;
        bit   pop;
        ent_t e;
        if (!rst) begin
            model_reset();
            return;
        end
        n_before = m_q.size();
        pop      = (n_before != 0) && out_ready && !redir_valid;
        if (pop) begin
            void'(m_q.pop_front());
        end
        if (m_busy) begin
            if (iresp.data_ok) begin
                if (m_doomed || redir_valid) begin
                    if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
                end else begin
                    e.pc    = m_addr;
                    e.instr = iresp.data[31:0];
                    m_q.push_back(e);
                    m_fresh = 1'b0;
                    m_fpc   = m_fpc + 64'd4;
                end
                m_busy = 1'b0;
            end else if (redir_valid) begin
                m_doomed = 1'b1;
            end
        end else if (!redir_valid && n_before < DEPTH) begin
            m_busy   = 1'b1;
            m_doomed = 1'b0;
            m_addr   = m_fpc;
        end
        if (redir_valid) begin
            m_fpc = redir_pc;
            m_q.delete();
        end
    endfunction

    task automatic check_outputs();
        chk("ireq_valid", 64'(ireq.valid), 64'(m_busy));
        if (m_busy) chk("ireq_addr", ireq.addr, m_addr);
        chk("ireq_unused_fields", 64'({ireq.size, ireq.wr}), 64'd0);
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("occupancy", 64'(occupancy), 64'(m_q.size()));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (m_q.size() != 0) begin
            chk("out_pc", out_pc, m_q[0].pc);
            chk("out_instr", 64'(out_instr), 64'(m_q[0].instr));
        end else if (m_fresh) begin
            chk("out_pc_reset", out_pc, 64'd0);
            chk("out_instr_reset", 64'(out_instr), 64'd0);
        end
    endtask

    function automatic logic [63:0] pick_target();
        logic [63:0] t;
        case ($urandom_range(0, 3))
            0:       t = 64'hFFFF_FFFF_FFFF_FFF8;   // exercises 64-bit wrap of fpc
            1:       t = 64'h8000_1000 + 64'({$urandom_range(0, 3), 12'h000});
            default: t = {32'h0, 32'h8000_0000 + ($urandom & 32'h0000_FFFC)};
        endcase
        return t;
    endfunction

    initial begin
        rst         = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 64'd0;
        out_ready   = 1'b0;
        iresp       = '0;
        model_reset();
        @(posedge clk);

        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            check_outputs();

            rst         = 1'b1;
            redir_valid = 1'b0;
            redir_pc    = pick_target();
            out_ready   = 1'b1;
            iresp       = '0;
            iresp.data  = {$urandom, $urandom};
            iresp.err   = 1'($urandom_range(0, 1));

            if (cyc < 2) begin
                rst = 1'b0;
            end else if (cyc < 120) begin
                // streaming: every response comes back immediately, consumer always ready
                iresp.data_ok = m_busy;
            end else if (cyc < 200) begin
                // stalled consumer: queue fills and issue must stop
                out_ready     = 1'b0;
                iresp.data_ok = m_busy;
            end else if (cyc < 215) begin
                // single pop after a full queue, then stall again
                out_ready     = (cyc == 200);
                iresp.data_ok = m_busy;
            end else if (cyc < 900) begin
                out_ready     = 1'($urandom_range(0, 1));
                iresp.data_ok = m_busy && ($urandom_range(0, 2) == 0);
                redir_valid   = ($urandom_range(0, 9) == 0);
                rst           = ($urandom_range(0, 99) != 0);
            end else begin
                // redirect-heavy: redirects in DROP, together with data_ok, back to back
                out_ready     = ($urandom_range(0, 3) != 0);
                iresp.data_ok = m_busy && ($urandom_range(0, 1) == 0);
                redir_valid   = ($urandom_range(0, 9) < 3);
                rst           = ($urandom_range(0, 149) != 0);
            end

            model_step();
        end

        @(negedge clk);
        check_outputs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queue entries; legal values are powers of two >= 2.
REQ-002 Parameter RESET_PC, default 64'h8000_0000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, synchronous and active-low.
REQ-005 ireq  output  ibus_req_t  SHALL carry the instruction fetch request; only the valid and addr fields are driven, and other fields are 0.
REQ-006 iresp  input  ibus_resp_t  SHALL carry the response; only data_ok and data[31:0] are used.
REQ-007 redir_valid  input  1  SHALL be a one-cycle redirect strobe from branch resolution.
REQ-008 redir_pc  input  64  SHALL be the redirect target, sampled when redir_valid=1.
REQ-009 out_valid  output  1  SHALL flag that the head entry is valid.
REQ-010 out_ready  input  1  SHALL mean the consumer accepts the head entry this cycle.
REQ-011 out_pc / out_instr  output  64 / 32  SHALL give the head entry's PC and instruction.
REQ-012 occupancy  output  $clog2(DEPTH)+1  SHALL give the current entry count.
REQ-013 drop_cnt  output  32  SHALL count discarded responses, saturating at 32'hFFFF_FFFF.

Function
REQ-014 FSM states SHALL be IDLE, REQ and DROP; ireq.valid SHALL be 1 exactly in REQ or DROP.
REQ-015 IDLE->REQ SHALL occur when occupancy<DEPTH and no redirect is in that cycle; ireq.addr SHALL equal fpc, held stable until data_ok.
REQ-016 When in REQ with data_ok and no redirect, the unit SHALL push {fpc, iresp.data} at the tail, set fpc<=fpc+4 (64-bit wrap) and go to IDLE; this gives one bubble between requests.
REQ-017 A pushed entry SHALL appear at out_* the cycle after data_ok (1-cycle latency) when the queue was empty.
REQ-018 Pop SHALL occur when out_valid&&out_ready; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-019 Because issue is gated by occupancy<DEPTH and at most 1 request is outstanding, push SHALL never overflow; pop when empty SHALL have no effect.
REQ-020 Head/tail pointers SHALL wrap modulo DEPTH.
REQ-021 A redirect SHALL flush the queue (occupancy<=0, out_valid=0 next cycle) and set fpc<=redir_pc; a pop in the same cycle SHALL be discarded.
REQ-022 A redirect in REQ without data_ok SHALL move the FSM to DROP; ireq.addr SHALL stay at the old address, and fpc SHALL still take redir_pc.
REQ-023 In DROP, data_ok SHALL discard the data, increment drop_cnt and go to IDLE; no push and no fpc increment SHALL occur.
REQ-024 A redirect in the same cycle as data_ok in REQ SHALL discard that data (count as a drop) and go to IDLE, with fpc<=redir_pc.
REQ-025 A redirect while in DROP SHALL update fpc only and keep the FSM in DROP; the latest redirect SHALL win.
REQ-026 A redirect in IDLE SHALL suppress issue that cycle; the next request SHALL use redir_pc.

Reset
REQ-027 rst=0 at a clock edge SHALL force state IDLE, fpc=RESET_PC, occupancy=0, pointers=0, drop_cnt=0.
REQ-028 Output values during and after reset: ireq.valid=0, out_valid=0, out_pc=0, out_instr=0.
REQ-029 Reset mid-request (REQ or DROP) SHALL abandon the request with no push and no drop count.
REQ-030 The first request after reset SHALL be issued in the second cycle after rst returns to 1.

Verification
REQ-031 Reset release, out_ready=1, data_ok 1 cycle after each valid -> addrs 8000_0000, 8000_0004, 8000_0008, …; each out_pc matches its addr with 1-cycle latency.
REQ-032 DEPTH=4, out_ready=0 -> exactly 4 responses pushed, occupancy=4, ireq.valid stays 0; one pop -> one more request issued.
REQ-033 Redirect to 8000_1000 while REQ for 8000_0008 is pending -> addr held at 8000_0008 until data_ok, data dropped, drop_cnt=1, next addr 8000_1000.
REQ-034 Redirect and data_ok in the same cycle, with 2 entries queued -> occupancy=0 next cycle, drop_cnt+1, next addr = redir_pc.
REQ-035 Two redirects (…2000 then …3000) while in DROP -> after data_ok the next addr is 8000_3000.
REQ-036 rst=0 asserted in REQ with 3 entries queued -> next cycle occupancy=0, ireq.valid=0; after release, the fetch restarts at 8000_0000.
